// File: rtl/cache_pkg.sv
// Shared types and address-field layout for the compressed-cache sequencing controller.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned TAG_FIELD  = 19;
    localparam int unsigned SET_COUNT  = 128;
    localparam int unsigned WAY_COUNT  = 8;
    localparam int unsigned LINE_WORDS = 16;

    localparam int unsigned TAG_LSB  = 13;
    localparam int unsigned SET_LSB  = 6;
    localparam int unsigned WORD_LSB = 2;

    localparam int unsigned SET_BITS   = $clog2(SET_COUNT);
    localparam int unsigned WAY_BITS   = $clog2(WAY_COUNT);
    localparam int unsigned WORD_BITS  = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_BITS = WAY_BITS + SET_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StResp,
        StMissReq,
        StFill,
        StCommit
    } state_e;

    // way*SET_COUNT + set, with SET_COUNT a power of two
    function automatic logic [INDEX_BITS-1:0] line_index(input logic [WAY_BITS-1:0] way,
                                                         input logic [SET_BITS-1:0] set);
        return {way, set};
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// Core, cache-array and memory channels of the cache controller.
interface cache_ctrl_if;
    import cache_pkg::*;

    logic                   cpu_req_valid;
    logic                   cpu_req_ready;
    logic [ADDR_WIDTH-1:0]  cpu_req_addr;
    logic                   cpu_rsp_valid;
    logic                   cpu_rsp_ready;
    logic [WORD_WIDTH-1:0]  cpu_rsp_data;

    logic [SET_BITS-1:0]    cache_read_index;
    logic [TAG_FIELD-1:0]   cache_read_tag;
    logic [WORD_BITS-1:0]   cache_read_word_addr;
    logic                   cache_read_hit;
    logic [WORD_WIDTH-1:0]  cache_read_word_data;

    logic [INDEX_BITS-1:0]  cache_write_index;
    logic                   cache_write_word_valid;
    logic [WORD_WIDTH-1:0]  cache_write_word;
    logic                   cache_write_on_demand;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_rsp_valid;
    logic [WORD_WIDTH-1:0]  mem_rsp_data;

    modport master (
        input  cpu_req_valid, cpu_req_addr, cpu_rsp_ready,
        input  cache_read_hit, cache_read_word_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
        output cache_read_index, cache_read_tag, cache_read_word_addr,
        output cache_write_index, cache_write_word_valid, cache_write_word, cache_write_on_demand,
        output mem_req_valid, mem_req_addr
    );

    modport slave (
        output cpu_req_valid, cpu_req_addr, cpu_rsp_ready,
        output cache_read_hit, cache_read_word_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
        input  cache_read_index, cache_read_tag, cache_read_word_addr,
        input  cache_write_index, cache_write_word_valid, cache_write_word, cache_write_on_demand,
        input  mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/victim_rr.sv
// Per-set round-robin victim way pointers, cleared by synchronous active-low reset.
module victim_rr
    import cache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SET_BITS-1:0] rd_set_i,
    output logic [WAY_BITS-1:0] rd_way_o,
    input  logic [SET_BITS-1:0] inc_set_i,
    input  logic                inc_en_i
);

    logic [WAY_BITS-1:0] ptr_q [SET_COUNT];

    // WAY_BITS-wide add wraps 7 -> 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SET_COUNT; i++) begin
                ptr_q[i] <= '0;
            end
        end else if (inc_en_i) begin
            ptr_q[inc_set_i] <= ptr_q[inc_set_i] + 1'b1;
        end
    end

    assign rd_way_o = ptr_q[rd_set_i];

endmodule

// File: rtl/cache_ctrl.sv
// Read-request sequencer: lookup, hit response, and miss line fill into a round-robin victim way.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus
);

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:WORD_LSB] addr_q, addr_d;
    logic [WORD_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic [WORD_BITS-1:0]       cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]      windex_q, windex_d;

    logic [SET_BITS-1:0]        set;
    logic [WAY_BITS-1:0]        victim_way;
    logic                       ptr_inc;

    assign set = addr_q[SET_LSB +: SET_BITS];

    victim_rr u_victim_rr (
        .clk_i     (clk),
        .rst_ni    (rst),
        .rd_set_i  (set),
        .rd_way_o  (victim_way),
        .inc_set_i (set),
        .inc_en_i  (ptr_inc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
            windex_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
            windex_q   <= windex_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        windex_d   = windex_q;
        ptr_inc    = 1'b0;

        bus.cpu_req_ready          = 1'b0;
        bus.cpu_rsp_valid          = 1'b0;
        bus.cpu_rsp_data           = rsp_data_q;
        bus.cache_read_index       = '0;
        bus.cache_read_tag         = '0;
        bus.cache_read_word_addr   = '0;
        bus.cache_write_index      = windex_q;
        bus.cache_write_word_valid = 1'b0;
        bus.cache_write_word       = '0;
        bus.cache_write_on_demand  = 1'b0;
        bus.mem_req_valid          = 1'b0;
        bus.mem_req_addr           = '0;

        if (state_q != StIdle) begin
            bus.cache_read_index     = set;
            bus.cache_read_tag       = addr_q[TAG_LSB +: TAG_FIELD];
            bus.cache_read_word_addr = addr_q[WORD_LSB +: WORD_BITS];
        end

        unique case (state_q)
            StIdle: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    addr_d  = bus.cpu_req_addr[ADDR_WIDTH-1:WORD_LSB];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (bus.cache_read_hit) begin
                    rsp_data_d = bus.cache_read_word_data;
                    state_d    = StResp;
                end else begin
                    // victim fixed here; the pointer only advances on commit
                    windex_d = line_index(victim_way, set);
                    state_d  = StMissReq;
                end
            end
            StResp: begin
                bus.cpu_rsp_valid = 1'b1;
                if (bus.cpu_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            StMissReq: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {addr_q[ADDR_WIDTH-1:SET_LSB], {SET_LSB{1'b0}}};
                if (bus.mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (bus.mem_rsp_valid) begin
                    bus.cache_write_word_valid = 1'b1;
                    bus.cache_write_word       = bus.mem_rsp_data;
                    cnt_d                      = cnt_q + 1'b1;
                    if (cnt_q == WORD_BITS'(LINE_WORDS - 1)) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                bus.cache_write_on_demand = 1'b1;
                ptr_inc                   = 1'b1;
                cnt_d                     = '0;
                state_d                   = StLookup;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: array/memory models, vector table, directed and random reads.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if bus ();

    cache_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [9:0]  idx;
        logic [31:0] data;
        logic [31:0] fill_base;
        int          bubble;
        int          rsp_stall;
        int          mreq_stall;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_addr = '0;

    // Cache array model, indexed way*128 + set
    logic [18:0] arr_tag   [1024];
    bit          arr_valid [1024];
    logic [31:0] arr_data  [1024][16];
    // Expected round-robin victim per set
    int          ref_ptr   [128];

    always_comb begin
        logic [9:0] li;
        li = '0;
        bus.cache_read_hit       = 1'b0;
        bus.cache_read_word_data = '0;
        for (int w = 0; w < 8; w++) begin
            li = {3'(w), bus.cache_read_index};
            if (arr_valid[li] && arr_tag[li] == bus.cache_read_tag) begin
                bus.cache_read_hit       = 1'b1;
                bus.cache_read_word_data = arr_data[li][bus.cache_read_word_addr];
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s addr=%08h: got %0h, expected %0h", name, cur_addr, act, exp);
        end
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        logic [9:0] li;
        for (int w = 0; w < 8; w++) begin
            li = {3'(w), a[12:6]};
            if (arr_valid[li] && arr_tag[li] == a[31:13]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] mem_base(input logic [31:0] a);
        return {a[31:6], 6'b0} ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mkv(input logic [31:0] addr, input bit miss, input logic [9:0] idx,
                                 input logic [31:0] data, input logic [31:0] base, input int bubble,
                                 input int rsp_stall, input int mreq_stall);
        vec_t v;
        v.addr = addr; v.miss = miss; v.idx = idx; v.data = data; v.fill_base = base;
        v.bubble = bubble; v.rsp_stall = rsp_stall; v.mreq_stall = mreq_stall;
        return v;
    endfunction

    // One complete read transaction, acting as core and memory.
    task automatic do_read(input vec_t v);
        int          k, strobes, pulses, mreq_cnt, stall, rsp_k, wait_c, wsent;
        bit          go_fill, filling, rsp_done, done, seen_mreq, give, junk;
        bit          ready_bad, stable_bad, order_bad, idx_bad, junk_bad, addr_bad;
        logic [31:0] held;
        k = 0; strobes = 0; pulses = 0; mreq_cnt = 0; stall = 0; rsp_k = 0; wsent = 0;
        go_fill = 0; filling = 0; rsp_done = 0; done = 0; seen_mreq = 0;
        ready_bad = 0; stable_bad = 0; order_bad = 0; idx_bad = 0; junk_bad = 0; addr_bad = 0;
        held = '0;
        cur_addr = v.addr;
        wait_c = 0;
        while (!bus.cpu_req_ready && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        chk("req_ready_idle", 32'(bus.cpu_req_ready), 32'd1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = v.addr;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = $urandom;
        k = 1;
        while (!done && k < 300) begin
            if (rsp_done) begin
                bus.cpu_rsp_ready = 1'b0;
                done = 1;
                chk("rsp_valid_after", 32'(bus.cpu_rsp_valid), 32'd0);
                chk("req_ready_after", 32'(bus.cpu_req_ready), 32'd1);
            end else begin
                if (bus.cpu_req_ready) ready_bad = 1;
                if (go_fill) begin
                    bus.mem_req_ready = 1'b0;
                    go_fill = 0;
                    filling = 1;
                end
                if (bus.mem_req_valid) begin
                    seen_mreq = 1;
                    if (bus.mem_req_addr !== {v.addr[31:6], 6'b0}) addr_bad = 1;
                    if (mreq_cnt < v.mreq_stall) begin
                        mreq_cnt++;
                        bus.mem_req_ready = 1'b0;
                    end else begin
                        bus.mem_req_ready = 1'b1;
                        go_fill = 1;
                    end
                end
                if (bus.cache_write_on_demand) begin
                    pulses++;
                    if (strobes != 16) order_bad = 1;
                    arr_valid[bus.cache_write_index] = 1'b1;
                    arr_tag[bus.cache_write_index]   = v.addr[31:13];
                end
                give = 0;
                junk = 0;
                if (filling && wsent < 16) begin
                    case (v.bubble)
                        0:       give = 1;
                        1:       give = (k % 2 == 0);
                        default: give = 1'($urandom_range(0, 1));
                    endcase
                end else if (bus.mem_req_valid && !bus.mem_req_ready) begin
                    junk = 1;  // stray fill data while the request is stalled
                end
                bus.mem_rsp_valid = give | junk;
                bus.mem_rsp_data  = give ? v.fill_base + 32'(wsent) : (32'hFFFF_0000 ^ 32'(k));
                #1;
                if (bus.cache_write_word_valid) begin
                    strobes++;
                    if (!give) begin
                        junk_bad = 1;
                    end else begin
                        if (bus.cache_write_word !== v.fill_base + 32'(wsent)) order_bad = 1;
                        if (bus.cache_write_index !== v.idx) idx_bad = 1;
                        arr_data[bus.cache_write_index][wsent] = bus.cache_write_word;
                        arr_valid[bus.cache_write_index]       = 1'b0;
                    end
                end else if (give) begin
                    order_bad = 1;
                end
                if (give) wsent++;
                if (filling && wsent == 16) filling = 0;
                if (bus.cpu_rsp_valid) begin
                    if (rsp_k == 0) begin
                        rsp_k = k;
                        held  = bus.cpu_rsp_data;
                    end else if (bus.cpu_rsp_data !== held) begin
                        stable_bad = 1;
                    end
                    if (stall < v.rsp_stall) begin
                        stall++;
                        bus.cpu_rsp_ready = 1'b0;
                    end else begin
                        bus.cpu_rsp_ready = 1'b1;
                        rsp_done = 1;
                    end
                end
            end
            @(negedge clk);
            k++;
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        chk("txn_done", 32'(done), 32'd1);
        chk("rsp_data", held, v.data);
        if (!v.miss) chk("hit_latency", 32'(rsp_k), 32'd2);
        chk("mem_req_seen", 32'(seen_mreq), 32'(v.miss));
        chk("fill_strobes", 32'(strobes), v.miss ? 32'd16 : 32'd0);
        chk("commit_pulses", 32'(pulses), 32'(v.miss));
        chk("req_ready_low", 32'(ready_bad), 32'd0);
        if (v.rsp_stall > 0) chk("rsp_stable", 32'(stable_bad), 32'd0);
        if (v.miss) begin
            chk("mem_req_addr", 32'(addr_bad), 32'd0);
            chk("fill_order", 32'(order_bad | junk_bad), 32'd0);
            chk("write_index", 32'(idx_bad), 32'd0);
            chk("mem_req_held", 32'(mreq_cnt), 32'(v.mreq_stall));
            ref_ptr[v.addr[12:6]] = (ref_ptr[v.addr[12:6]] + 1) % 8;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [13];
        vec_t        rv;
        logic [31:0] a;
        logic [9:0]  pidx;
        int          s, t, wd, strobes, wait_c;
        bit          pulse_seen;

        for (int i = 0; i < 1024; i++) begin
            arr_valid[i] = 1'b0;
            arr_tag[i]   = '0;
        end
        for (int i = 0; i < 128; i++) ref_ptr[i] = 0;
        // Preload: addr 0x2044 -> tag 1, set 1, word 1, placed in way 3
        arr_valid[10'h181]   = 1'b1;
        arr_tag[10'h181]     = 19'd1;
        arr_data[10'h181][1] = 32'hDEAD_BEEF;

        tbl[0] = mkv(32'h0000_2044, 0, 10'h000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        tbl[1] = mkv(32'h0001_0080, 1, 10'h002, 32'h0000_0100, 32'h100, 0, 0, 0);
        tbl[2] = mkv(32'h0001_00BC, 0, 10'h000, 32'h0000_010F, 32'h0, 0, 5, 0);
        for (int i = 0; i < 9; i++) begin
            tbl[3+i] = mkv(((32'h40 + 32'(i)) << 13) | (32'd5 << 6), 1,
                           10'(((i % 8) << 7) | 5), 32'h0002_0000 + 32'(i) * 32'h100,
                           32'h0002_0000 + 32'(i) * 32'h100,
                           (i == 0) ? 1 : ((i == 1) ? 2 : 0),
                           (i == 2) ? 5 : 0, (i == 2) ? 3 : ((i == 3) ? 1 : 0));
        end
        tbl[12] = mkv((32'h41 << 13) | (32'd5 << 6) | (32'd3 << 2), 0, 10'h000,
                      32'h0002_0103, 32'h0, 0, 0, 0);

        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_rsp_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_on_demand", 32'(bus.cache_write_on_demand), 32'd0);
        chk("rst_rsp_data", bus.cpu_rsp_data, 32'd0);
        chk("rst_write_index", 32'(bus.cache_write_index), 32'd0);
        chk("rst_read_index", 32'(bus.cache_read_index), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) do_read(tbl[i]);

        // Response accepted while a new request is already valid
        cur_addr = tbl[12].addr;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = tbl[12].addr;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        wait_c = 0;
        while (!bus.cpu_rsp_valid && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        chk("ovl_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd1);
        bus.cpu_rsp_ready = 1'b1;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h0001_00BC;
        @(negedge clk);
        chk("ovl_idle_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        chk("ovl_idle_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        bus.cpu_rsp_ready = 1'b0;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        chk("ovl_accept_req_ready", 32'(bus.cpu_req_ready), 32'd0);
        chk("ovl_accept_set", 32'(bus.cache_read_index), 32'd2);
        wait_c = 0;
        while (!bus.cpu_rsp_valid && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        chk("ovl_second_data", bus.cpu_rsp_data, 32'h0000_010F);
        bus.cpu_rsp_ready = 1'b1;
        @(negedge clk);
        bus.cpu_rsp_ready = 1'b0;

        // Random reads over a few sets, enough tags to force evictions
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = 2;
                2:       s = 5;
                default: s = 9;
            endcase
            t  = 32 + int'($urandom_range(0, 9));
            wd = int'($urandom_range(0, 15));
            a  = (32'(t) << 13) | (32'(s) << 6) | (32'(wd) << 2) | 32'($urandom_range(0, 3));
            rv = mkv(a, !model_hit(a), 10'((ref_ptr[s] << 7) | s), mem_base(a) + 32'(wd),
                     mem_base(a), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            do_read(rv);
        end

        // Reset during fill: build up pointer state in set 7 first
        a = (32'h50 << 13) | (32'd7 << 6);
        do_read(mkv(a, !model_hit(a), 10'((ref_ptr[7] << 7) | 7), mem_base(a), mem_base(a),
                    0, 0, 0));
        a = (32'h51 << 13) | (32'd7 << 6);
        cur_addr = a;
        pidx = 10'((ref_ptr[7] << 7) | 7);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = a;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        wait_c = 0;
        while (!bus.mem_req_valid && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        chk("rmid_mem_req", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        strobes = 0;
        pulse_seen = 0;
        for (int w = 0; w < 7; w++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'h0300_0000 + 32'(w);
            #1;
            if (bus.cache_write_word_valid) strobes++;
            @(negedge clk);
            if (bus.cache_write_on_demand) pulse_seen = 1;
        end
        chk("rmid_partial_strobes", 32'(strobes), 32'd7);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h0300_0007;
        @(negedge clk);
        if (bus.cache_write_on_demand) pulse_seen = 1;
        chk("rmid_word_valid", 32'(bus.cache_write_word_valid), 32'd0);
        chk("rmid_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rmid_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        chk("rmid_write_index", 32'(bus.cache_write_index), 32'd0);
        chk("rmid_read_index", 32'(bus.cache_read_index), 32'd0);
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        if (bus.cache_write_on_demand) pulse_seen = 1;
        chk("rmid_no_commit", 32'(pulse_seen), 32'd0);
        chk("rmid_idle_ready", 32'(bus.cpu_req_ready), 32'd1);
        for (int i = 0; i < 128; i++) ref_ptr[i] = 0;
        arr_valid[pidx] = 1'b0;

        // Pointers were cleared, so the next set-7 miss goes to way 0
        a = (32'h52 << 13) | (32'd7 << 6) | (32'd9 << 2);
        do_read(mkv(a, 1, 10'h007, mem_base(a) + 32'd9, mem_base(a), 1, 0, 0));
        a = (32'h50 << 13) | (32'd7 << 6) | (32'd4 << 2);
        do_read(mkv(a, 1, 10'h087, mem_base(a) + 32'd4, mem_base(a), 0, 2, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
